ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle control sequencer for the sample processor: the parametrised successor of the combinational control decoder. It decodes each instruction from instruction ROM, drives the register-file, data-memory and program-counter enables, and stretches loads over a configurable memory latency. It also adds conditional relative branching on the ALU zero flag, a start/done program handshake and a retired-instruction counter. It sits between instruction ROM/ALU flags and the program counter, register file and data memory.

## Interface

Parameters:
- IW, 9, instruction width; the opcode is Instruction[IW-1:IW-3].
- MEM_LAT, 2, data-memory read latency in cycles; legal range is 1 to 15.
- CW, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  level; starts a program from IDLE or DONE.
- Instruction  input  IW  machine code from instruction ROM.
- Zero  input  1  ALU zero flag for the current cycle.
- RegWrEn  output  1  register-file write enable.
- MemWrEn  output  1  data-memory write enable (stores only).
- LoadInst  output  1  selects memory, not the ALU, as the register-file write source.
- BranchRel  output  1  PC takes a relative branch at the next edge.
- PCTarg  output  2  branch target LUT index, equal to Instruction[3:2].
- PcEn  output  1  PC advances or branches at the next edge.
- Busy  output  1  high in the RUN and LOAD states.
- Ack  output  1  high in the DONE state.
- InstCount  output  CW  number of retired instructions.

## Operation

States and transitions:
- IDLE → RUN when Start=1.
- RUN → LOAD when a load is decoded and MEM_LAT>1.
- RUN → DONE when the Ack instruction is decoded.
- LOAD → RUN when the wait count expires.
- DONE → RUN when Start=1.
- Start has no effect in RUN and LOAD.

Opcode decoding in RUN:
- Opcodes: 110 is store, 111 is load, 101 is branch; every other opcode is an ALU operation.
- The all-ones instruction is Ack. It takes priority over the load decode.
- Store: MemWrEn=1, RegWrEn=0, PcEn=1.
- ALU operation: RegWrEn=1, PcEn=1.
- Branch: RegWrEn=1 and PcEn=1.
  - If Instruction[5]=0, BranchRel=1 unconditionally.
  - If Instruction[5]=1, BranchRel=Zero.
- Load with MEM_LAT=1: LoadInst=1, RegWrEn=1, PcEn=1, completing in a single cycle.
- Load with MEM_LAT>1: LoadInst=1, RegWrEn=0, PcEn=0. The wait counter is loaded with MEM_LAT-1 and the block enters LOAD.
- Ack: all enables are 0 and PcEn=0; the block enters DONE.

LOAD state:
- LoadInst=1 and PcEn=0, so the instruction is held.
- The counter decrements every cycle.
- In the cycle where the counter equals 1, RegWrEn=1 and PcEn=1, and the next state is RUN.
- Instruction is not re-decoded while in LOAD.

Outputs outside RUN and LOAD:
- In IDLE and DONE, all enables (RegWrEn, MemWrEn, LoadInst, BranchRel, PcEn) are 0.
- PCTarg always equals Instruction[3:2].

InstCount:
- Increments at every edge where PcEn=1.
- Saturates at 2^CW-1; it does not wrap.
- Cleared by Reset, and on the edge that takes IDLE or DONE into RUN.

## Timing

- Reset values: state is IDLE, the wait counter is 0, InstCount is 0. All outputs are 0 except PCTarg, which equals Instruction[3:2].
- Enables are combinational from state and Instruction, valid in the same cycle the instruction is presented. The PC, register file and memory act on them at the following edge.
- Single-cycle instructions: one instruction per cycle; PcEn is high continuously.
- Loads occupy exactly MEM_LAT cycles.
  - LoadInst is high for all MEM_LAT cycles.
  - RegWrEn and PcEn are high only in the last cycle.
- Ack instruction: DONE is entered at the next edge and Ack rises one cycle after the Ack instruction is presented. Ack stays high until a Start restart.
- Start sampled high in DONE: Ack falls and Busy rises at that edge.
- Reset asserted mid-load: the block returns to IDLE immediately. No RegWrEn pulse is issued, and the counter does not increment.
- Zero is sampled only for conditional branches, in the same cycle as the branch.

## Test plan

- Reset, then Start=1, then ALU op 9'b000_000_000 for 3 cycles: RegWrEn=1 and PcEn=1 each cycle; InstCount reads 3.
- Load 9'b111_000_000 with MEM_LAT=3: LoadInst=1 for 3 cycles; RegWrEn and PcEn are high only in cycle 3; InstCount increments by exactly 1.
- Conditional branch 9'b101_100_100:
  - With Zero=1: BranchRel=1 and PCTarg=2'b01.
  - With Zero=0: BranchRel=0 and PcEn=1.
  - Unconditional form 9'b101_000_100 gives BranchRel=1 regardless of Zero.
- Store 9'b110_000_000: MemWrEn=1 and RegWrEn=0. Instruction 9'b111111111: Ack=1 from the next cycle; all enables are 0; Start=1 restarts, clearing Ack and InstCount.
- Reset asserted in the second cycle of a MEM_LAT=3 load: outputs are zero immediately; no RegWrEn pulse; the block is in IDLE.
- With CW=2, run 5 ALU ops: InstCount saturates at 3.

Source files
------------

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle control sequencer: decode, load stretching, branch, start/done, retire count
// Enables are combinational from state and Instruction; the PC, register file and memory act on the next edge.
module ctrl_seq #(
  parameter int IW      = 9,
  parameter int MEM_LAT = 2,
  parameter int CW      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  input  logic          Zero,
  output logic          RegWrEn,
  output logic          MemWrEn,
  output logic          LoadInst,
  output logic          BranchRel,
  output logic [1:0]    PCTarg,
  output logic          PcEn,
  output logic          Busy,
  output logic          Ack,
  output logic [CW-1:0] InstCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_STORE  = 3'b110;
  localparam logic [2:0] OP_LOAD   = 3'b111;
  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic [CW-1:0] count_q, count_d;

  logic [2:0] opcode;
  logic       is_ack;

  assign opcode = Instruction[IW-1:IW-3];
  assign is_ack = &Instruction;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    LoadInst  = 1'b0;
    BranchRel = 1'b0;
    PcEn      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) state_d = S_RUN;
      end
      S_RUN: begin
        // Ack is all-ones, so it must be tested before the load opcode
        if (is_ack) begin
          state_d = S_DONE;
        end else begin
          case (opcode)
            OP_LOAD: begin
              LoadInst = 1'b1;
              if (MEM_LAT == 1) begin
                RegWrEn = 1'b1;
                PcEn    = 1'b1;
              end else begin
                wait_d  = WAIT_INIT;
                state_d = S_LOAD;
              end
            end
            OP_STORE: begin
              MemWrEn = 1'b1;
              PcEn    = 1'b1;
            end
            OP_BRANCH: begin
              RegWrEn   = 1'b1;
              PcEn      = 1'b1;
              BranchRel = Instruction[5] ? Zero : 1'b1;
            end
            default: begin
              RegWrEn = 1'b1;
              PcEn    = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        LoadInst = 1'b1;
        wait_d   = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          RegWrEn = 1'b1;
          PcEn    = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && state_d == S_RUN)
      count_d = '0;
    else if (PcEn && count_q != {CW{1'b1}})
      count_d = count_q + 1'b1;
  end

  assign PCTarg    = Instruction[3:2];
  assign Busy      = (state_q == S_RUN) || (state_q == S_LOAD);
  assign Ack       = (state_q == S_DONE);
  assign InstCount = count_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - random and directed check of ctrl_seq against a behavioural model
// Two instances share stimulus: MEM_LAT=3/CW=16 and MEM_LAT=1/CW=2.
module tb_ctrl_seq;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [8:0] Instruction = 9'd0;
  logic       Zero = 1'b0;

  logic        rw0, mw0, li0, br0, pc0, busy0, ack0;
  logic [1:0]  pt0;
  logic [15:0] cnt0;
  logic        rw1, mw1, li1, br1, pc1, busy1, ack1;
  logic [1:0]  pt1;
  logic [1:0]  cnt1;

  always #5 Clk = ~Clk;

  ctrl_seq #(.IW(9), .MEM_LAT(3), .CW(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .Zero(Zero),
    .RegWrEn(rw0), .MemWrEn(mw0), .LoadInst(li0), .BranchRel(br0), .PCTarg(pt0),
    .PcEn(pc0), .Busy(busy0), .Ack(ack0), .InstCount(cnt0)
  );

  ctrl_seq #(.IW(9), .MEM_LAT(1), .CW(2)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .Zero(Zero),
    .RegWrEn(rw1), .MemWrEn(mw1), .LoadInst(li1), .BranchRel(br1), .PCTarg(pt1),
    .PcEn(pc1), .Busy(busy1), .Ack(ack1), .InstCount(cnt1)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model: running/done flags, cycles already spent in the current load, retired count
  int lat [2] = '{3, 1};
  int cwv [2] = '{16, 2};
  bit m_run [2] = '{1'b0, 1'b0};
  bit m_done[2] = '{1'b0, 1'b0};
  int m_ld  [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};

  // {RegWrEn, MemWrEn, LoadInst, BranchRel, PcEn, Busy, Ack, PCTarg}
  function automatic logic [8:0] expect_out(int i);
    logic rw = 1'b0, mw = 1'b0, li = 1'b0, br = 1'b0, pc = 1'b0;
    logic [2:0] op;
    op = Instruction[8:6];
    if (m_run[i]) begin
      if (m_ld[i] > 0) begin
        li = 1'b1;
        rw = (m_ld[i] + 1 == lat[i]);
        pc = rw;
      end else if (Instruction == 9'h1FF) begin
        rw = 1'b0;
      end else if (op == 3'b111) begin
        li = 1'b1;
        if (lat[i] == 1) begin rw = 1'b1; pc = 1'b1; end
      end else if (op == 3'b110) begin
        mw = 1'b1; pc = 1'b1;
      end else if (op == 3'b101) begin
        rw = 1'b1; pc = 1'b1;
        br = Instruction[5] ? Zero : 1'b1;
      end else begin
        rw = 1'b1; pc = 1'b1;
      end
    end
    return {rw, mw, li, br, pc, m_run[i], m_done[i], Instruction[3:2]};
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 1'b0; m_done[i] = 1'b0; m_ld[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [8:0] e;
        e = expect_out(i);
        if (!m_run[i]) begin
          if (Start) begin m_run[i] = 1'b1; m_done[i] = 1'b0; m_cnt[i] = 0; end
        end else if (m_ld[i] > 0) begin
          m_ld[i] = (m_ld[i] + 1 == lat[i]) ? 0 : m_ld[i] + 1;
        end else if (Instruction == 9'h1FF) begin
          m_run[i] = 1'b0; m_done[i] = 1'b1;
        end else if (Instruction[8:6] == 3'b111 && lat[i] > 1) begin
          m_ld[i] = 1;
        end
        if (e[4] && m_cnt[i] < (1 << cwv[i]) - 1) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      logic [8:0] act [2];
      int         acnt[2];
      act[0] = {rw0, mw0, li0, br0, pc0, busy0, ack0, pt0};
      act[1] = {rw1, mw1, li1, br1, pc1, busy1, ack1, pt1};
      acnt[0] = int'(cnt0);
      acnt[1] = int'(cnt1);
      for (int i = 0; i < 2; i++) begin
        logic [8:0] e;
        e = expect_out(i);
        checks++;
        if (act[i] !== e) begin
          errors++;
          $display("FAIL outputs dut%0d t=%0t: got %b expected %b (rw mw li br pc busy ack pctarg)",
                   i, $time, act[i], e);
        end
        checks++;
        if (acnt[i] != m_cnt[i]) begin
          errors++;
          $display("FAIL inst_count dut%0d t=%0t: got %0d expected %0d", i, $time, acnt[i], m_cnt[i]);
        end
      end
    end
  end

  task automatic cyc(input logic s, input logic [8:0] ins, input logic z, input logic r = 1'b0);
    @(posedge Clk);
    #1;
    Start = s; Instruction = ins; Zero = z; Reset = r;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  localparam logic [8:0] LD  = 9'b111_000_000;
  localparam logic [8:0] ST  = 9'b110_000_000;
  localparam logic [8:0] BRC = 9'b101_100_100;
  localparam logic [8:0] BRU = 9'b101_000_100;
  localparam logic [8:0] ACK = 9'b111_111_111;

  initial begin
    cyc(0, 9'd0, 0, 1);
    chk_on = 1'b1;
    cyc(0, 9'd0, 0, 1);
    cyc(0, 9'd0, 0, 0);
    @(negedge Clk);
    chk("reset_busy_ack_enables", int'({busy0, ack0, rw0, mw0, li0, br0, pc0}), 0);
    chk("reset_count", int'(cnt0), 0);

    cyc(1, 9'd0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 9'd0, 0);
      @(negedge Clk);
      chk("alu_rw_pc", int'({rw0, pc0}), 3);
    end
    cyc(0, LD, 0);
    @(negedge Clk);
    chk("count_after_3_alu", int'(cnt0), 3);
    chk("load_c1_li_rw_pc", int'({li0, rw0, pc0}), 4);
    cyc(0, LD, 0);
    @(negedge Clk);
    chk("load_c2_li_rw_pc", int'({li0, rw0, pc0}), 4);
    cyc(0, LD, 0);
    @(negedge Clk);
    chk("load_c3_li_rw_pc", int'({li0, rw0, pc0}), 7);

    cyc(0, BRC, 1);
    @(negedge Clk);
    chk("count_after_load", int'(cnt0), 4);
    chk("brc_z1_br_pctarg", int'({br0, pt0}), 5);
    cyc(0, BRC, 0);
    @(negedge Clk);
    chk("brc_z0_br_pc", int'({br0, pc0}), 1);
    cyc(0, BRU, 0);
    @(negedge Clk);
    chk("bru_z0_br", int'(br0), 1);
    cyc(0, ST, 0);
    @(negedge Clk);
    chk("store_mw_rw", int'({mw0, rw0}), 2);
    cyc(0, ACK, 0);
    @(negedge Clk);
    chk("ack_instr_enables_ack", int'({rw0, mw0, li0, br0, pc0, ack0}), 0);
    cyc(0, 9'd0, 0);
    @(negedge Clk);
    chk("done_ack_busy", int'({ack0, busy0}), 2);
    cyc(1, 9'd0, 0);
    @(negedge Clk);
    chk("done_start_cycle_ack", int'(ack0), 1);
    cyc(0, 9'd0, 0);
    @(negedge Clk);
    chk("restart_ack_busy_count", int'({ack0, busy0, cnt0}), 65536);

    cyc(0, LD, 0);
    cyc(0, LD, 0, 1);
    @(negedge Clk);
    chk("midload_reset_outputs", int'({rw0, li0, pc0, busy0, ack0}), 0);
    chk("midload_reset_count", int'(cnt0), 0);
    cyc(0, 9'd0, 0, 0);
    @(negedge Clk);
    chk("after_reset_idle", int'({busy0, ack0, rw0}), 0);

    cyc(1, 9'd0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 9'd0, 0);
    cyc(0, 9'd0, 0);
    @(negedge Clk);
    chk("cw2_saturate", int'(cnt1), 3);
    chk("cw16_count5", int'(cnt0), 5);

    for (int n = 0; n < 3000; n++) begin
      logic       s, z, r;
      logic [8:0] ins;
      int         k;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      z = 1'($urandom_range(0, 1));
      ins = 9'($urandom);
      k = $urandom_range(0, 15);
      if (k == 0) ins = ACK;
      else if (k <= 3) ins[8:6] = 3'b111;
      else if (k <= 5) ins[8:6] = 3'b110;
      else if (k <= 8) ins[8:6] = 3'b101;
      cyc(s, ins, z, r);
    end
    cyc(0, 9'd0, 0, 0);
    @(negedge Clk);
    #1;
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
